// File: rtl/x2050_lad_arb_if.sv
// Left adder input arbiter bundle: CPU and channel
// requests in, registered adder select and status out.
interface x2050_lad_arb_if;
  logic       i_cpu_req;
  logic       i_cpu_hold;
  logic [2:0] i_cpu_lx;
  logic       i_cpu_tc;
  logic       i_ch_req;
  logic [2:0] i_ch_lx;
  logic       i_ch_tc;
  logic [1:0] i_ch_ioreg;
  logic       o_io_mode;
  logic [2:0] o_lx;
  logic       o_tc;
  logic [1:0] o_ioreg;
  logic       o_cpu_stall;
  logic       o_ch_grant;
  logic       o_ch_done;
  logic [1:0] o_state;

  modport master (
    output i_cpu_req, i_cpu_hold,
    output i_cpu_lx, i_cpu_tc,
    output i_ch_req, i_ch_lx,
    output i_ch_tc, i_ch_ioreg,
    input  o_io_mode, o_lx, o_tc,
    input  o_ioreg, o_cpu_stall,
    input  o_ch_grant, o_ch_done,
    input  o_state
  );

  modport slave (
    input  i_cpu_req, i_cpu_hold,
    input  i_cpu_lx, i_cpu_tc,
    input  i_ch_req, i_ch_lx,
    input  i_ch_tc, i_ch_ioreg,
    output o_io_mode, o_lx, o_tc,
    output o_ioreg, o_cpu_stall,
    output o_ch_grant, o_ch_done,
    output o_state
  );
endinterface

// File: rtl/x2050_lad_arb.sv
// Left adder input arbiter: shares the adder between
// CPU microword cycles and channel break-in sequences.
module x2050_lad_arb #(
  parameter int BRK_CYCLES  = 4,
  parameter int MAX_CPU_RUN = 8
) (
  input logic             i_clk,
  input logic             i_reset,
  x2050_lad_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    BRK  = 2'd2
  } state_t;

  localparam int CW =
    (BRK_CYCLES > 1) ? $clog2(BRK_CYCLES) : 1;
  localparam int RW = $clog2(MAX_CPU_RUN + 1);
  localparam logic [CW-1:0] BRK_LAST =
    CW'(BRK_CYCLES - 1);
  localparam logic [RW-1:0] RUN_MAX =
    RW'(MAX_CPU_RUN);

  state_t        state_q, state_d;
  logic [CW-1:0] brk_q, brk_d;
  logic [RW-1:0] run_q, run_d;
  logic          in_brk;
  logic          brk_last;
  logic          cpu_win;
  logic          brk_start;

  // run_q is always 0 inside BRK, so the exit
  // decision lets a requesting CPU win.
  always_comb begin
    in_brk    = (state_q == BRK);
    brk_last  = in_brk && (brk_q == BRK_LAST);
    cpu_win   = bus.i_cpu_req &
                (~bus.i_ch_req | bus.i_cpu_hold |
                 (run_q < RUN_MAX));
    brk_start = bus.i_ch_req & ~cpu_win;
    state_d   = state_q;
    brk_d     = brk_q;
    run_d     = run_q;
    if (in_brk && !brk_last) begin
      state_d = BRK;
      brk_d   = brk_q + CW'(1);
    end else if (brk_start) begin
      state_d = BRK;
      brk_d   = '0;
    end else if (cpu_win) begin
      state_d = CPU;
    end else begin
      state_d = IDLE;
    end
    if (!bus.i_ch_req || state_d == BRK) begin
      run_d = '0;
    end else if (state_d == CPU &&
                 run_q != RUN_MAX) begin
      run_d = run_q + RW'(1);
    end
  end

  assign bus.o_cpu_stall = ~i_reset &
    bus.i_cpu_req & (state_d != CPU);
  assign bus.o_state = state_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= IDLE;
      brk_q          <= '0;
      run_q          <= '0;
      bus.o_io_mode  <= 1'b0;
      bus.o_lx       <= 3'd0;
      bus.o_tc       <= 1'b1;
      bus.o_ioreg    <= 2'd0;
      bus.o_ch_grant <= 1'b0;
      bus.o_ch_done  <= 1'b0;
    end else begin
      state_q        <= state_d;
      brk_q          <= brk_d;
      run_q          <= run_d;
      bus.o_ch_grant <= (state_d == BRK);
      bus.o_ch_done  <= (state_d == BRK) &&
                        (brk_d == BRK_LAST);
      unique case (state_d)
        CPU: begin
          bus.o_io_mode <= 1'b0;
          bus.o_lx      <= bus.i_cpu_lx;
          bus.o_tc      <= bus.i_cpu_tc;
          bus.o_ioreg   <= 2'd0;
        end
        BRK: begin
          bus.o_io_mode <= 1'b1;
          bus.o_lx      <= bus.i_ch_lx;
          bus.o_tc      <= bus.i_ch_tc;
          bus.o_ioreg   <= bus.i_ch_ioreg;
        end
        default: begin
          bus.o_io_mode <= 1'b0;
          bus.o_lx      <= 3'd0;
          bus.o_tc      <= 1'b1;
          bus.o_ioreg   <= 2'd0;
        end
      endcase
    end
  end

endmodule
